// File: rtl/mips_core_pkg.sv
// -----------------------------------------------------------------------------
// mips_core_pkg
// Shared definitions for the MIPS core runahead controller:
//   - ra_state_e : runahead controller FSM states (IDLE, WAIT, RUNAHEAD, EXIT)
//   - RA_*_DEF   : default values for the runahead_ctrl / runahead_inv_file
//                  parameters, so the defaults are defined in a single place.
// -----------------------------------------------------------------------------
package mips_core_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    RUNAHEAD = 2'd2,
    EXIT     = 2'd3
  } ra_state_e;

  localparam int RA_ADDR_WIDTH_DEF      = 26;
  localparam int RA_REG_ADDR_WIDTH_DEF  = 5;
  localparam int RA_ENTRY_THRESHOLD_DEF = 4;
  localparam int RA_MAX_RA_CYCLES_DEF   = 256;
  localparam int RA_STAT_W              = 32;

endpackage

// File: rtl/runahead_inv_file.sv
// -----------------------------------------------------------------------------
// runahead_inv_file
// One INV bit per architectural register, tracking which registers hold
// bogus (miss-dependent) values while the core is in runahead.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears all bits)
//   i_clear           clear every bit (runahead exit)
//   i_set_en/addr     mark the stalled load's destination invalid (entry)
//   i_wb_en/addr/inv  WB-stage write: INV[addr] <= inv
//   i_rd_en           read enable; reads return 0 when low
//   i_rs_addr/rt_addr DEC-stage source registers to look up
//   o_rs_inv/o_rt_inv source invalid flags, with same-cycle WB bypass
//
// Register 0 is hard-wired valid: it is never stored and never bypassed.
// -----------------------------------------------------------------------------
module runahead_inv_file
  import mips_core_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = RA_REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_set_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_set_addr,
  input  logic                      i_wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_addr,
  input  logic                      i_wb_inv,
  input  logic                      i_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rt_addr,
  output logic                      o_rs_inv,
  output logic                      o_rt_inv
);

  localparam int NREG = 1 << REG_ADDR_WIDTH;

  logic [NREG-1:0] inv_q;
  logic [NREG-1:0] inv_d;
  logic            rs_byp;
  logic            rt_byp;

  always_comb begin
    inv_d = inv_q;
    if (i_clear) begin
      inv_d = '0;
    end else begin
      if (i_set_en) inv_d[i_set_addr] = 1'b1;
      // WB is applied after the entry set so a same-cycle write wins
      if (i_wb_en)  inv_d[i_wb_addr]  = i_wb_inv;
    end
    inv_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= '0;
    else        inv_q <= inv_d;
  end

  // A WB write to the register being read this cycle is forwarded so the
  // decode stage never sees a stale INV bit.
  assign rs_byp = i_wb_en && (i_wb_addr == i_rs_addr);
  assign rt_byp = i_wb_en && (i_wb_addr == i_rt_addr);

  assign o_rs_inv = i_rd_en && (i_rs_addr != '0) &&
                    (rs_byp ? i_wb_inv : inv_q[i_rs_addr]);
  assign o_rt_inv = i_rd_en && (i_rt_addr != '0) &&
                    (rt_byp ? i_wb_inv : inv_q[i_rt_addr]);

endmodule

// File: rtl/runahead_ctrl.sv
// -----------------------------------------------------------------------------
// runahead_ctrl
// Runahead execution controller. When a MEM-stage load stays blocked on a
// d-cache miss for ENTRY_THRESHOLD consecutive cycles, the core checkpoints
// the load PC and enters runahead; it leaves when the miss resolves or the
// MAX_RA_CYCLES budget runs out, flushing and redirecting to the checkpoint.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_miss_valid/pc/rw_addr         stalled load, its PC and destination reg
//   i_miss_resolved                 blocking refill complete (pulse)
//   i_wb_uses_rw/rw_addr/inv        WB-stage write and its invalid flag
//   i_rs_addr/i_rt_addr             DEC-stage sources
//   o_rs_inv/o_rt_inv               source marked invalid (runahead only)
//   o_runahead_mode                 high in RUNAHEAD and EXIT
//   o_enter                         one-cycle pulse, first runahead cycle
//   o_flush/o_load_pc_valid/o_load_pc  exit flush and redirect (EXIT cycle)
//   o_checkpoint_pc                 registered checkpoint PC
//   o_entry_count/o_ra_cycle_count  statistics, only with RUNAHEAD_STATS_EN
//
// Configuration macro: RUNAHEAD_STATS_EN adds the two saturating 32-bit
// statistics counters and their output ports.
//
// Stall counting: the counter value seen with the "+1" applied is the number
// of consecutive miss cycles including the current one, so entry is decided
// on the ENTRY_THRESHOLD-th miss cycle. Runahead cycles are counted the same
// way; the cycle that reaches MAX_RA_CYCLES moves to EXIT on the next edge.
// -----------------------------------------------------------------------------
module runahead_ctrl
  import mips_core_pkg::*;
#(
  parameter int ADDR_WIDTH      = RA_ADDR_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH  = RA_REG_ADDR_WIDTH_DEF,
  parameter int ENTRY_THRESHOLD = RA_ENTRY_THRESHOLD_DEF,
  parameter int MAX_RA_CYCLES   = RA_MAX_RA_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_miss_valid,
  input  logic [ADDR_WIDTH-1:0]     i_miss_pc,
  input  logic [REG_ADDR_WIDTH-1:0] i_miss_rw_addr,
  input  logic                      i_miss_resolved,
  input  logic                      i_wb_uses_rw,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rw_addr,
  input  logic                      i_wb_inv,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rt_addr,
  output logic                      o_rs_inv,
  output logic                      o_rt_inv,
  output logic                      o_runahead_mode,
  output logic                      o_enter,
  output logic                      o_flush,
  output logic                      o_load_pc_valid,
  output logic [ADDR_WIDTH-1:0]     o_load_pc,
`ifdef RUNAHEAD_STATS_EN
  output logic [RA_STAT_W-1:0]      o_entry_count,
  output logic [RA_STAT_W-1:0]      o_ra_cycle_count,
`endif
  output logic [ADDR_WIDTH-1:0]     o_checkpoint_pc
);

  localparam int STALL_W = $clog2(ENTRY_THRESHOLD + 1);
  localparam int RA_W    = $clog2(MAX_RA_CYCLES + 1);

  localparam logic [STALL_W-1:0] STALL_THR = STALL_W'(ENTRY_THRESHOLD);
  localparam logic [RA_W-1:0]    RA_MAX    = RA_W'(MAX_RA_CYCLES);

  ra_state_e             state_q, state_d;
  logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [RA_W-1:0]       ra_cnt_q, ra_cnt_d;
  logic [ADDR_WIDTH-1:0] ckpt_q, ckpt_d;
  logic                  enter_q, enter_d;

  logic [STALL_W-1:0]    stall_inc;
  logic [RA_W-1:0]       ra_inc;
  logic                  entry_fire;
  logic                  inv_clear;
  logic                  in_ra;

  // Saturating increments; they can never wrap back to zero.
  assign stall_inc = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + STALL_W'(1);
  assign ra_inc    = (ra_cnt_q == '1)    ? ra_cnt_q    : ra_cnt_q + RA_W'(1);

  assign in_ra = (state_q == RUNAHEAD);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    ra_cnt_d    = ra_cnt_q;
    ckpt_d      = ckpt_q;
    enter_d     = 1'b0;
    entry_fire  = 1'b0;
    inv_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_miss_valid && !i_miss_resolved) begin
          // stall_cnt_q is 0 here, so stall_inc is 1: this is miss cycle 1
          if (stall_inc == STALL_THR) begin
            entry_fire = 1'b1;
          end else begin
            state_d     = WAIT;
            stall_cnt_d = stall_inc;
          end
        end
      end

      WAIT: begin
        // A resolve arriving on the threshold cycle cancels the entry
        if (!i_miss_valid || i_miss_resolved) begin
          state_d     = IDLE;
          stall_cnt_d = '0;
        end else if (stall_inc == STALL_THR) begin
          entry_fire = 1'b1;
        end else begin
          stall_cnt_d = stall_inc;
        end
      end

      RUNAHEAD: begin
        // Further misses are deliberately ignored: runahead never nests
        ra_cnt_d = ra_inc;
        if (i_miss_resolved || (ra_inc == RA_MAX)) begin
          state_d = EXIT;
        end
      end

      EXIT: begin
        state_d   = IDLE;
        ra_cnt_d  = '0;
        inv_clear = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (entry_fire) begin
      state_d     = RUNAHEAD;
      stall_cnt_d = '0;
      ra_cnt_d    = '0;
      ckpt_d      = i_miss_pc;
      enter_d     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      ra_cnt_q    <= '0;
      ckpt_q      <= '0;
      enter_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      ra_cnt_q    <= ra_cnt_d;
      ckpt_q      <= ckpt_d;
      enter_q     <= enter_d;
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // drops them immediately and no redirect can escape.
  assign o_runahead_mode = (state_q == RUNAHEAD) || (state_q == EXIT);
  assign o_enter         = enter_q;
  assign o_flush         = (state_q == EXIT);
  assign o_load_pc_valid = (state_q == EXIT);
  assign o_load_pc       = (state_q == EXIT) ? ckpt_q : '0;
  assign o_checkpoint_pc = ckpt_q;

  // ---------------------------------------------------------------------------
  // INV bit file
  // ---------------------------------------------------------------------------
  runahead_inv_file #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_inv_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (inv_clear),
    .i_set_en   (entry_fire),
    .i_set_addr (i_miss_rw_addr),
    .i_wb_en    (i_wb_uses_rw && in_ra),
    .i_wb_addr  (i_wb_rw_addr),
    .i_wb_inv   (i_wb_inv),
    .i_rd_en    (in_ra),
    .i_rs_addr  (i_rs_addr),
    .i_rt_addr  (i_rt_addr),
    .o_rs_inv   (o_rs_inv),
    .o_rt_inv   (o_rt_inv)
  );

`ifdef RUNAHEAD_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
  logic [RA_STAT_W-1:0] entry_count_q, entry_count_d;
  logic [RA_STAT_W-1:0] ra_cycle_count_q, ra_cycle_count_d;

  function automatic logic [RA_STAT_W-1:0] sat_inc(input logic [RA_STAT_W-1:0] v);
    return (v == '1) ? v : v + RA_STAT_W'(1);
  endfunction

  always_comb begin
    entry_count_d    = entry_count_q;
    ra_cycle_count_d = ra_cycle_count_q;
    if (entry_fire)      entry_count_d    = sat_inc(entry_count_q);
    if (o_runahead_mode) ra_cycle_count_d = sat_inc(ra_cycle_count_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_count_q    <= '0;
      ra_cycle_count_q <= '0;
    end else begin
      entry_count_q    <= entry_count_d;
      ra_cycle_count_q <= ra_cycle_count_d;
    end
  end

  assign o_entry_count    = entry_count_q;
  assign o_ra_cycle_count = ra_cycle_count_q;
`endif

endmodule

// File: doc/runahead_ctrl.md
RUNAHEAD_CTRL -- requirements
Module: runahead_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 26, byte-address width of all PC ports.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, architectural register index width (2**REG_ADDR_WIDTH registers).
REQ-003 Parameter ENTRY_THRESHOLD, default 4, consecutive miss-stall cycles required before runahead entry (legal range 1..255).
REQ-004 Parameter MAX_RA_CYCLES, default 256, runahead cycle budget before forced exit (legal range 1..65535).
REQ-005 clk  in  1  core clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 i_miss_valid  in  1  MEM-stage load is stalled on a d-cache miss.
REQ-008 i_miss_pc  in  ADDR_WIDTH  PC of the stalled load.
REQ-009 i_miss_rw_addr  in  REG_ADDR_WIDTH  destination register of the stalled load.
REQ-010 i_miss_resolved  in  1  refill of the blocking line is complete (one-cycle pulse).
REQ-011 i_wb_uses_rw / i_wb_rw_addr / i_wb_inv  in  1 / REG_ADDR_WIDTH / 1  WB-stage write, its register, and whether its result is invalid.
REQ-012 i_rs_addr / i_rt_addr  in  REG_ADDR_WIDTH each  DEC-stage source registers.
REQ-013 o_rs_inv / o_rt_inv  out  1 each  source register currently marked invalid.
REQ-014 o_runahead_mode  out  1  core is in runahead; architectural events suppressed.
REQ-015 o_enter  out  1  one-cycle pulse on runahead entry.
REQ-016 o_flush / o_load_pc_valid / o_load_pc  out  1 / 1 / ADDR_WIDTH  exit flush and PC redirect to checkpoint.
REQ-017 o_checkpoint_pc  out  ADDR_WIDTH  registered checkpoint PC.

Function
REQ-018 FSM states SHALL be IDLE, WAIT, RUNAHEAD, EXIT.
REQ-019 IDLE: i_miss_valid=1 -> WAIT, stall counter loaded with 1.
REQ-020 WAIT: counter increments each cycle i_miss_valid=1; i_miss_resolved=1 or i_miss_valid=0 -> IDLE, counter cleared, no entry.
REQ-021 WAIT: counter==ENTRY_THRESHOLD and i_miss_resolved=0 -> RUNAHEAD; same cycle capture checkpoint=i_miss_pc, set INV[i_miss_rw_addr], pulse o_enter next cycle.
REQ-022 Simultaneous threshold reach and i_miss_resolved: resolved wins, -> IDLE.
REQ-023 RUNAHEAD: o_runahead_mode=1; cycle counter increments per cycle; i_miss_resolved=1 or counter==MAX_RA_CYCLES -> EXIT.
REQ-024 RUNAHEAD: i_miss_valid from later missing loads ignored for entry; no nesting.
REQ-025 EXIT: exactly one cycle with o_flush=1, o_load_pc_valid=1, o_load_pc=checkpoint, o_runahead_mode=1; next cycle IDLE, all INV bits cleared, o_runahead_mode=0.
REQ-026 INV update only in RUNAHEAD: i_wb_uses_rw=1 writes INV[i_wb_rw_addr]=i_wb_inv; register 0 never marked.
REQ-027 o_rs_inv/o_rt_inv combinational from INV bits, forced 0 outside RUNAHEAD; WB write to same register same cycle SHALL be bypassed.
REQ-028 Counters saturate, never wrap; widths sized from parameters with $clog2.

Reset
REQ-029 rst_n low (any time, incl. mid-runahead) SHALL immediately force IDLE, counters 0, INV 0, checkpoint 0, all outputs 0; no exit redirect issued.

Configuration
REQ-030 Macro RUNAHEAD_STATS_EN defined: add outputs o_entry_count (32) and o_ra_cycle_count (32), incremented per entry and per RUNAHEAD/EXIT cycle, saturating, reset 0.
REQ-031 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-032 FSM state enum and default parameter constants SHALL live in the shared mips_core package.
REQ-033 INV bit vector with bypassed read SHALL be sub-module runahead_inv_file; FSM and counters stay in runahead_ctrl.

Verification
REQ-034 Threshold 4: i_miss_valid high 4 cycles, pc=0x100 -> o_enter pulse, o_runahead_mode=1, o_checkpoint_pc=0x100.
REQ-035 i_miss_valid high 3 cycles then resolved -> no entry, o_runahead_mode stays 0.
REQ-036 In runahead, i_miss_resolved pulse -> one cycle o_flush=1, o_load_pc=0x100, then IDLE, o_rs_inv=0 for all addresses.
REQ-037 MAX_RA_CYCLES=8, no resolve -> EXIT on runahead cycle 8.
REQ-038 Runahead, WB r5 inv=1 with i_rs_addr=5 same cycle -> o_rs_inv=1; WB r0 inv=1 -> o_rs_inv=0 for r0.
REQ-039 rst_n low mid-runahead -> all outputs 0 asynchronously, no redirect; with RUNAHEAD_STATS_EN, counters read 0.
